// File: rtl/trng_word_buffer.sv
// First-word-fall-through buffer for the TRNG word stream. The source cannot be
// stalled, so words arriving while full are dropped and counted.
module trng_word_buffer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              word_in,
   input  logic                     word_valid,
   input  logic                     clear,
   output logic [31:0]              rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count,
   output logic                     repeat_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [31:0]    mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic           overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic           repeat_err_q, repeat_err_d;
   logic [31:0]    prev_q, prev_d;
   logic           prev_ok_q, prev_ok_d;

   logic           full;
   logic           pop;
   logic           push;
   logic           drop;

   // Handshake: a word leaves the buffer on any edge where rd_valid and
   // rd_ready are both high; rd_data holds steady while rd_ready is low.
   assign rd_valid   = (level_q != '0);
   assign rd_data    = mem_q[rd_ptr_q];
   assign level      = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign repeat_err = repeat_err_q;

   assign full = (level_q == LW'(DEPTH));
   assign pop  = rd_valid & rd_ready & ~clear;
   assign push = word_valid & ~clear & (~full | pop);
   assign drop = word_valid & ~clear & full & ~pop;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      repeat_err_d = repeat_err_q;
      prev_d       = prev_q;
      prev_ok_d    = prev_ok_q;
      if (clear) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         overflow_d   = 1'b0;
         drop_count_d = '0;
         repeat_err_d = 1'b0;
         prev_ok_d    = 1'b0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (push && !pop)      level_d = level_q + LW'(1);
         else if (pop && !push) level_d = level_q - LW'(1);
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
         end
         // Dropped words still feed the repeat check: it watches the source.
         if (word_valid) begin
            if (prev_ok_q && (word_in == prev_q)) repeat_err_d = 1'b1;
            prev_d    = word_in;
            prev_ok_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
         repeat_err_q <= 1'b0;
         prev_q       <= '0;
         prev_ok_q    <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         repeat_err_q <= repeat_err_d;
         prev_q       <= prev_d;
         prev_ok_q    <= prev_ok_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= word_in;
      end
   end

endmodule

// File: tb/tb_trng_word_buffer.sv
// Directed bench for trng_word_buffer: ordering, overflow, full+pop, repeat
// flag, clear, counter saturation and asynchronous reset.
module tb_trng_word_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        clear = 1'b0;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [4:0]  level;
   logic        overflow;
   logic [15:0] drop_count;
   logic        repeat_err;

   logic [31:0] s_word_in = '0;
   logic        s_word_valid = 1'b0;
   logic        s_clear = 1'b0;
   logic        s_rd_ready = 1'b0;
   logic [31:0] s_rd_data;
   logic        s_rd_valid;
   logic [2:0]  s_level;
   logic        s_overflow;
   logic [3:0]  s_drop_count;
   logic        s_repeat_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trng_word_buffer #(.DEPTH(16), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .clear(clear), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .level(level), .overflow(overflow), .drop_count(drop_count),
      .repeat_err(repeat_err)
   );

   trng_word_buffer #(.DEPTH(4), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .word_in(s_word_in), .word_valid(s_word_valid),
      .clear(s_clear), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
      .rd_ready(s_rd_ready), .level(s_level), .overflow(s_overflow),
      .drop_count(s_drop_count), .repeat_err(s_repeat_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      #2;
      check("rst_level", 32'(level), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      check("rst_repeat_err", 32'(repeat_err), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // three words, then drain
      word_valid = 1'b1;
      word_in = 32'hA5A5_0001; tick();
      check("first_visible", rd_data, 32'hA5A5_0001);
      check("first_valid", 32'(rd_valid), 32'd1);
      word_in = 32'hA5A5_0002; tick();
      word_in = 32'hA5A5_0003; tick();
      word_valid = 1'b0;
      check("three_level", 32'(level), 32'd3);
      check("three_head", rd_data, 32'hA5A5_0001);
      tick();
      check("head_stable", rd_data, 32'hA5A5_0001);
      rd_ready = 1'b1;
      check("out1", rd_data, 32'hA5A5_0001); tick();
      check("out2", rd_data, 32'hA5A5_0002); tick();
      check("out3", rd_data, 32'hA5A5_0003); tick();
      rd_ready = 1'b0;
      check("drained_valid", 32'(rd_valid), 32'd0);
      check("drained_level", 32'(level), 32'd0);
      tick();
      check("empty_ready_level", 32'(level), 32'd0);

      // overflow: 18 words into 16 entries
      word_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
         word_in = 32'h1000_0000 + 32'(i);
         tick();
      end
      word_valid = 1'b0;
      check("ovf_level", 32'(level), 32'd16);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_drops", 32'(drop_count), 32'd2);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_out", rd_data, 32'h1000_0000 + 32'(i));
         tick();
      end
      rd_ready = 1'b0;
      check("ovf_drained", 32'(rd_valid), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      clear = 1'b1; tick(); clear = 1'b0;
      check("clr_overflow", 32'(overflow), 32'd0);
      check("clr_drops", 32'(drop_count), 32'd0);

      // full with simultaneous push and pop
      word_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         word_in = 32'h2000_0000 + 32'(i);
         tick();
      end
      check("full_level", 32'(level), 32'd16);
      word_in = 32'hDEAD_BEEF;
      rd_ready = 1'b1;
      check("fp_out0", rd_data, 32'h2000_0000);
      tick();
      word_valid = 1'b0;
      check("fp_level", 32'(level), 32'd16);
      check("fp_drops", 32'(drop_count), 32'd0);
      check("fp_overflow", 32'(overflow), 32'd0);
      for (int i = 1; i < 16; i++) begin
         check("fp_out", rd_data, 32'h2000_0000 + 32'(i));
         tick();
      end
      check("fp_last", rd_data, 32'hDEAD_BEEF);
      tick();
      rd_ready = 1'b0;
      check("fp_drained", 32'(level), 32'd0);
      check("no_repeat_yet", 32'(repeat_err), 32'd0);

      // repeated word
      word_valid = 1'b1;
      word_in = 32'h1234_5678; tick();
      check("rep_after_one", 32'(repeat_err), 32'd0);
      tick();
      word_valid = 1'b0;
      check("rep_set", 32'(repeat_err), 32'd1);
      check("rep_level", 32'(level), 32'd2);
      check("rep_head", rd_data, 32'h1234_5678);
      tick();
      check("rep_sticky", 32'(repeat_err), 32'd1);
      // clear ignores a same-cycle word
      clear = 1'b1; word_valid = 1'b1; rd_ready = 1'b1; tick();
      clear = 1'b0; rd_ready = 1'b0;
      check("clr_level", 32'(level), 32'd0);
      check("clr_repeat", 32'(repeat_err), 32'd0);
      check("clr_valid", 32'(rd_valid), 32'd0);
      tick();
      word_valid = 1'b0;
      check("post_clr_repeat", 32'(repeat_err), 32'd0);
      check("post_clr_level", 32'(level), 32'd1);
      check("post_clr_data", rd_data, 32'h1234_5678);

      // drop counter saturation on the small instance
      s_word_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         s_word_in = 32'h3000_0000 + 32'(i);
         tick();
         if (i == 18) check("sat_mid", 32'(s_drop_count), 32'd15);
      end
      s_word_valid = 1'b0;
      check("sat_count", 32'(s_drop_count), 32'd15);
      check("sat_overflow", 32'(s_overflow), 32'd1);
      check("sat_level", 32'(s_level), 32'd4);
      check("sat_head", s_rd_data, 32'h3000_0000);

      // asynchronous reset between edges with level 5
      word_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         word_in = 32'h4000_0000 + 32'(i);
         tick();
      end
      word_valid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_level", 32'(level), 32'd0);
      check("arst_valid", 32'(rd_valid), 32'd0);
      check("arst_data", rd_data, 32'd0);
      check("arst_sat_drops", 32'(s_drop_count), 32'd0);
      tick();
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
